mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control FSM: fetch/decode/exec/mem/wb sequencing,
// memory handshake timeout, and a retired-instruction counter.
module mc_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [4:0]       rt,
  input  logic [5:0]       func,
  input  logic             br_taken,
  input  logic             mem_ack,
  output logic             IRWr,
  output logic             PCWr,
  output logic [1:0]       PCsrc,
  output logic             MemRd,
  output logic             MemWr,
  output logic             RegWr,
  output logic             RegDst,
  output logic             ra,
  output logic             ALUsrc_A,
  output logic             ALUsrc_B,
  output logic             ExtOp,
  output logic [1:0]       MemtoReg,
  output logic [3:0]       ALUctr,
  output logic [2:0]       state,
  output logic             halted,
  output logic             error,
  output logic [RET_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6,
    S_BAD    = 3'd7
  } state_e;

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [WCW-1:0] TO_VAL = WCW'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [RET_W-1:0] ret_q, ret_d;

  logic legal, is_ld, is_st, is_br;
  logic is_j, is_jal, is_jr, is_jalr, is_halt;
  logic [3:0] alu;
  logic src_a, src_b, ext, rdst, ra_w;
  logic [1:0] m2r;

  logic ir_wr, pc_wr, mem_rd, mem_wr, reg_wr;
  logic [1:0] pc_src;

  always_comb begin
    legal   = 1'b1;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_br   = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_jalr = 1'b0;
    is_halt = 1'b0;
    alu     = 4'b0000;
    src_a   = 1'b0;
    src_b   = 1'b0;
    ext     = 1'b0;
    rdst    = 1'b0;
    ra_w    = 1'b0;
    m2r     = 2'b00;
    unique case (op)
      6'b000000: begin
        rdst = 1'b1;
        unique case (func)
          6'b100000: alu = 4'b0000;
          6'b100001: alu = 4'b0010;
          6'b100010: alu = 4'b0001;
          6'b100011: alu = 4'b0011;
          6'b000000: begin alu = 4'b0100; src_a = 1'b1; end
          6'b000100: alu = 4'b0100;
          6'b000010: begin alu = 4'b0101; src_a = 1'b1; end
          6'b000110: alu = 4'b0101;
          6'b000011: begin alu = 4'b0110; src_a = 1'b1; end
          6'b000111: alu = 4'b0110;
          6'b100100: alu = 4'b1010;
          6'b100101: alu = 4'b0111;
          6'b100110: alu = 4'b1001;
          6'b100111: alu = 4'b1000;
          6'b101010: alu = 4'b0001;
          6'b101011: alu = 4'b0011;
          6'b001000: is_jr = 1'b1;
          6'b001001: begin
            is_jalr = 1'b1;
            ra_w    = 1'b1;
            m2r     = 2'b10;
          end
          default: legal = 1'b0;
        endcase
      end
      6'b001000: begin alu = 4'b0000; src_b = 1'b1; ext = 1'b1; end
      6'b001001: begin alu = 4'b0010; src_b = 1'b1; ext = 1'b1; end
      6'b001010: begin alu = 4'b0001; src_b = 1'b1; ext = 1'b1; end
      6'b001011: begin alu = 4'b0011; src_b = 1'b1; ext = 1'b1; end
      6'b001100: begin alu = 4'b1010; src_b = 1'b1; end
      6'b001101: begin alu = 4'b0111; src_b = 1'b1; end
      6'b001110: begin alu = 4'b1001; src_b = 1'b1; end
      6'b001111: begin src_b = 1'b1; m2r = 2'b01; end
      6'b100011, 6'b100000, 6'b100100: begin
        is_ld = 1'b1;
        alu   = 4'b0010;
        src_b = 1'b1;
        ext   = 1'b1;
        m2r   = 2'b11;
      end
      6'b101011, 6'b101000: begin
        is_st = 1'b1;
        alu   = 4'b0010;
        src_b = 1'b1;
        ext   = 1'b1;
      end
      6'b000100, 6'b000101: begin
        is_br = 1'b1;
        alu   = 4'b0011;
        ext   = 1'b1;
      end
      6'b000110, 6'b000111: begin
        is_br = 1'b1;
        ext   = 1'b1;
      end
      6'b000001: begin
        is_br = 1'b1;
        ext   = 1'b1;
        legal = rt inside {5'b00000, 5'b00001};
      end
      6'b000010: is_j = 1'b1;
      6'b000011: begin
        is_jal = 1'b1;
        ra_w   = 1'b1;
        m2r    = 2'b10;
      end
      6'b111111: is_halt = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ret_d   = ret_q;
    ir_wr   = 1'b0;
    pc_wr   = 1'b0;
    pc_src  = 2'b00;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    reg_wr  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (TO_EN && wait_d == TO_VAL) state_d = S_ERR;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_ERR;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_j || is_jal) begin
          pc_wr   = 1'b1;
          pc_src  = 2'b10;
          reg_wr  = is_jal;
          state_d = S_FETCH;
        end else if (is_jr || is_jalr) begin
          pc_wr   = 1'b1;
          pc_src  = 2'b11;
          reg_wr  = is_jalr;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          pc_wr   = br_taken;
          pc_src  = 2'b01;
          state_d = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_rd = is_ld;
        mem_wr = !is_ld;
        if (mem_ack) begin
          state_d = is_ld ? S_WB : S_FETCH;
        end else begin
          wait_d = wait_q + 1'b1;
          if (TO_EN && wait_d == TO_VAL) state_d = S_ERR;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT, S_ERR: ;
      default: state_d = S_ERR;
    endcase
    // only DECODE..WB can enter FETCH, so every such entry retires one op
    if (state_d != state_q && state_d == S_FETCH) ret_d = ret_q + 1'b1;
    if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
      wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  assign IRWr     = ir_wr & rst_n;
  assign PCWr     = pc_wr & rst_n;
  assign MemRd    = mem_rd & rst_n;
  assign MemWr    = mem_wr & rst_n;
  assign RegWr    = reg_wr & rst_n;
  assign PCsrc    = pc_src;
  assign RegDst   = rdst;
  assign ra       = ra_w;
  assign ALUsrc_A = src_a;
  assign ALUsrc_B = src_b;
  assign ExtOp    = ext;
  assign MemtoReg = m2r;
  assign ALUctr   = alu;
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign error    = (state_q == S_ERR);
  assign retired  = ret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle expectations are queued by
// the driver and compared by a negedge monitor.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic [4:0]  rt;
  logic [5:0]  func;
  logic        br_taken;
  logic        mem_ack;
  logic        IRWr, PCWr, MemRd, MemWr, RegWr;
  logic        RegDst, ra, ALUsrc_A, ALUsrc_B, ExtOp;
  logic [1:0]  PCsrc, MemtoReg;
  logic [3:0]  ALUctr;
  logic [2:0]  state;
  logic        halted, error;
  logic [31:0] retired;

  mc_control_unit #(.MEM_TIMEOUT(4), .RET_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .rt(rt), .func(func),
    .br_taken(br_taken), .mem_ack(mem_ack),
    .IRWr(IRWr), .PCWr(PCWr), .PCsrc(PCsrc), .MemRd(MemRd),
    .MemWr(MemWr), .RegWr(RegWr), .RegDst(RegDst), .ra(ra),
    .ALUsrc_A(ALUsrc_A), .ALUsrc_B(ALUsrc_B), .ExtOp(ExtOp),
    .MemtoReg(MemtoReg), .ALUctr(ALUctr), .state(state),
    .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic [4:0]  stb;
    logic        cx;
    logic [1:0]  pcs;
    logic [1:0]  m2r;
    logic [3:0]  alu;
    logic        ra;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int vid = 0;
  logic [31:0] exp_ret = 0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s got %0h want %0h", id, nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", e.id, 32'(state), 32'(e.st));
      chk("strobes", e.id, 32'({IRWr, PCWr, MemRd, MemWr, RegWr}), 32'(e.stb));
      chk("retired", e.id, retired, e.ret);
      chk("halted", e.id, 32'(halted), 32'(e.st == 3'd5));
      chk("error", e.id, 32'(error), 32'(e.st == 3'd6));
      if (e.cx) begin
        chk("PCsrc", e.id, 32'(PCsrc), 32'(e.pcs));
        chk("MemtoReg", e.id, 32'(MemtoReg), 32'(e.m2r));
        chk("ALUctr", e.id, 32'(ALUctr), 32'(e.alu));
        chk("ra", e.id, 32'(ra), 32'(e.ra));
      end
    end
  end

  task automatic push(input logic [2:0] st, input logic [4:0] stb,
                      input logic x, input logic [1:0] pcs,
                      input logic [1:0] m2r, input logic [3:0] alu,
                      input logic r);
    exp_t e;
    e.id  = vid;
    e.st  = st;
    e.stb = stb;
    e.cx  = x;
    e.pcs = pcs;
    e.m2r = m2r;
    e.alu = alu;
    e.ra  = r;
    e.ret = exp_ret;
    sb.push_back(e);
    vid++;
  endtask

  // strobe order: {IRWr, PCWr, MemRd, MemWr, RegWr}
  task automatic cy(input logic [2:0] st, input logic [4:0] stb,
                    input logic ack, input logic br);
    mem_ack  = ack;
    br_taken = br;
    push(st, stb, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic cyx(input logic [2:0] st, input logic [4:0] stb,
                     input logic ack, input logic br,
                     input logic [1:0] pcs, input logic [1:0] m2r,
                     input logic [3:0] alu, input logic r);
    mem_ack  = ack;
    br_taken = br;
    push(st, stb, 1'b1, pcs, m2r, alu, r);
    @(posedge clk); #1;
  endtask

  task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
    op   = o;
    func = f;
    rt   = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_ir(6'b000000, 6'b100001);
    br_taken = 1'b0;
    mem_ack  = 1'b0;
    @(posedge clk); #1;
    cy(3'd0, 5'b00000, 1'b1, 1'b0);
    rst_n = 1'b1;

    // addu, ack in first FETCH cycle
    cyx(3'd0, 5'b11100, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0);
    cy (3'd1, 5'b00000, 1'b0, 1'b0);
    cyx(3'd2, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0);
    cyx(3'd4, 5'b00001, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0);
    exp_ret = 1;

    // lw, 3-cycle FETCH wait, 2-cycle MEM wait, stray acks ignored
    set_ir(6'b100011, 6'b000000);
    repeat (3) cy(3'd0, 5'b00100, 1'b0, 1'b0);
    cyx(3'd0, 5'b11100, 1'b1, 1'b0, 2'b00, 2'b11, 4'b0010, 1'b0);
    cy (3'd1, 5'b00000, 1'b1, 1'b0);
    cyx(3'd2, 5'b00000, 1'b1, 1'b0, 2'b00, 2'b11, 4'b0010, 1'b0);
    repeat (2) cy(3'd3, 5'b00100, 1'b0, 1'b0);
    cy (3'd3, 5'b00100, 1'b1, 1'b0);
    cyx(3'd4, 5'b00001, 1'b0, 1'b0, 2'b00, 2'b11, 4'b0010, 1'b0);
    exp_ret = 2;

    // beq taken, then bne not taken
    set_ir(6'b000100, 6'b000000);
    cy (3'd0, 5'b11100, 1'b1, 1'b0);
    cy (3'd1, 5'b00000, 1'b0, 1'b1);
    cyx(3'd2, 5'b01000, 1'b0, 1'b1, 2'b01, 2'b00, 4'b0011, 1'b0);
    exp_ret = 3;
    set_ir(6'b000101, 6'b000000);
    cy (3'd0, 5'b11100, 1'b1, 1'b0);
    cy (3'd1, 5'b00000, 1'b0, 1'b0);
    cyx(3'd2, 5'b00000, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0011, 1'b0);
    exp_ret = 4;

    // jal, then halt held for 20 cycles
    set_ir(6'b000011, 6'b000000);
    cy (3'd0, 5'b11100, 1'b1, 1'b0);
    cyx(3'd1, 5'b01001, 1'b0, 1'b0, 2'b10, 2'b10, 4'b0000, 1'b1);
    exp_ret = 5;
    set_ir(6'b111111, 6'b000000);
    cy (3'd0, 5'b11100, 1'b1, 1'b0);
    cy (3'd1, 5'b00000, 1'b0, 1'b0);
    repeat (20) cy(3'd5, 5'b00000, 1'b1, 1'b1);

    rst_n = 1'b0;
    cy(3'd5, 5'b00000, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_ret = 0;
    rst_n = 1'b1;

    // addu again so retired is nonzero before the mid-MEM reset
    set_ir(6'b000000, 6'b100001);
    cy(3'd0, 5'b11100, 1'b1, 1'b0);
    cy(3'd1, 5'b00000, 1'b0, 1'b0);
    cy(3'd2, 5'b00000, 1'b0, 1'b0);
    cy(3'd4, 5'b00001, 1'b0, 1'b0);
    exp_ret = 1;

    // sw, reset during MEM wait
    set_ir(6'b101011, 6'b000000);
    cy (3'd0, 5'b11100, 1'b1, 1'b0);
    cy (3'd1, 5'b00000, 1'b0, 1'b0);
    cyx(3'd2, 5'b00000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0010, 1'b0);
    repeat (2) cy(3'd3, 5'b00010, 1'b0, 1'b0);
    rst_n = 1'b0;
    cy(3'd3, 5'b00000, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_ret = 0;

    // FETCH timeout after 4 ack-less cycles; ERR absorbs acks
    repeat (4) cy(3'd0, 5'b00100, 1'b0, 1'b0);
    cy(3'd6, 5'b00000, 1'b0, 1'b0);
    repeat (3) cy(3'd6, 5'b00000, 1'b1, 1'b0);

    rst_n = 1'b0;
    cy(3'd6, 5'b00000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // unrecognised opcode in DECODE
    set_ir(6'b010000, 6'b000000);
    cy(3'd0, 5'b11100, 1'b1, 1'b0);
    cy(3'd1, 5'b00000, 1'b0, 1'b0);
    cy(3'd6, 5'b00000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
